// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the datapath-side request signals and the data-memory bus of the
// load/store unit into one interface.
//
// Signal summary:
//   cpu_req     datapath requests a load/store (level, held while stall=1)
//   cpu_we      1 = store, 0 = load
//   cpu_funct3  access size / signedness (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   cpu_addr    byte address
//   cpu_wdata   store data
//   cpu_rdata   extended load result, valid with cpu_done
//   cpu_done    one-cycle completion pulse
//   stall       holds PC and register write while an access is pending
//   misaligned  one-cycle pulse when an access is rejected
//   mem_req     bus request
//   mem_we      bus write
//   mem_addr    word-aligned bus address
//   mem_be      byte enables
//   mem_wdata   lane-replicated store data
//   mem_rdata   read word from memory
//   mem_ack     bus completion
//   bus_err     timeout pulse (present only when LSU_TIMEOUT_EN is defined)
//
// Modports:
//   master  the load/store unit itself (drives the memory bus and the
//           datapath result signals)
//   slave   the surroundings (datapath plus data memory)
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [2:0]        cpu_funct3;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;
    logic              stall;
    logic              misaligned;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
`ifdef LSU_TIMEOUT_EN
    logic              bus_err;
`endif

    modport master (
        input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        input  mem_rdata, mem_ack,
        output cpu_rdata, cpu_done, stall, misaligned,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
`ifdef LSU_TIMEOUT_EN
        , output bus_err
`endif
    );

    modport slave (
        output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        output mem_rdata, mem_ack,
        input  cpu_rdata, cpu_done, stall, misaligned,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
`ifdef LSU_TIMEOUT_EN
        , input bus_err
`endif
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Turns a single-cycle datapath load/store into a handshaked word-bus
// transaction: byte-lane enables, store-data replication, sign/zero
// extension of loads and misalignment rejection. stall holds the datapath
// until the access completes; memory latency is variable and completion is
// signalled with mem_ack.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-low reset
//   io_lsu  load_store_unit_if.master (datapath request + memory bus)
//
// Parameters:
//   ADDR_W          byte-address width
//   TIMEOUT_CYCLES  maximum BUS cycles waited for mem_ack (only with
//                   LSU_TIMEOUT_EN)
//
// Build option:
//   LSU_TIMEOUT_EN  when defined, a BUS wait counter aborts the access after
//                   TIMEOUT_CYCLES cycles without mem_ack and pulses bus_err
//                   together with cpu_done. When undefined, BUS waits
//                   indefinitely and there is no bus_err signal.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.master io_lsu
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [31:0]       r_cpuRdata;
    logic              r_cpuDone;
    logic              r_misaligned;
    logic              r_memReq;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [3:0]        r_memBe;
    logic [31:0]       r_memWdata;
    logic [1:0]        r_lane;
    logic [2:0]        r_funct3;

    logic              w_aligned;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_laneData;
    logic [31:0]       w_loadData;
    logic              w_doneHold;
    logic              w_stall;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]  r_waitCnt;
    logic              r_busErr;
`endif

    // Request decode: alignment, byte enables and lane-replicated store data.
    // Replicating the store data means every enabled lane already carries the
    // right byte, so no shifter is needed on the write path.
    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = io_lsu.cpu_wdata;
        case (io_lsu.cpu_funct3)
            3'b000, 3'b100: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << io_lsu.cpu_addr[1:0];
                w_wdata   = {4{io_lsu.cpu_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                w_aligned = ~io_lsu.cpu_addr[0];
                w_be      = 4'b0011 << io_lsu.cpu_addr[1:0];
                w_wdata   = {2{io_lsu.cpu_wdata[15:0]}};
            end
            3'b010: begin
                w_aligned = (io_lsu.cpu_addr[1:0] == 2'b00);
                w_be      = 4'b1111;
            end
            default: begin
                // 011/110/111 are not legal accesses and get rejected.
                w_aligned = 1'b0;
            end
        endcase
    end

    // Load result: shift the addressed lane down to bit 0, then extend.
    // Lane and funct3 were captured at request time because the datapath may
    // drop cpu_req (and change the address) while the bus cycle is pending.
    always_comb begin
        w_laneData = io_lsu.mem_rdata >> {r_lane, 3'b000};
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_laneData[7]}}, w_laneData[7:0]};
            3'b100:  w_loadData = {24'd0, w_laneData[7:0]};
            3'b001:  w_loadData = {{16{w_laneData[15]}}, w_laneData[15:0]};
            3'b101:  w_loadData = {16'd0, w_laneData[15:0]};
            default: w_loadData = w_laneData;
        endcase
    end

    // Stall is combinational so the datapath freezes in the very cycle the
    // request appears. In DONE it is released for one cycle so the datapath
    // advances; done_hold keeps that same instruction from re-issuing then.
    // Gating with reset keeps every output at 0 while reset is asserted.
    always_comb begin
        w_doneHold = (r_state == S_DONE);
        w_stall    = reset & ~w_doneHold &
                     ((r_state == S_BUS) | io_lsu.cpu_req);
    end

    // Main IDLE -> BUS -> DONE sequencer. Misaligned requests skip BUS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cpuRdata   <= 32'd0;
            r_cpuDone    <= 1'b0;
            r_misaligned <= 1'b0;
            r_memReq     <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memBe      <= 4'b0000;
            r_memWdata   <= 32'd0;
            r_lane       <= 2'b00;
            r_funct3     <= 3'b000;
`ifdef LSU_TIMEOUT_EN
            r_waitCnt    <= '0;
            r_busErr     <= 1'b0;
`endif
        end else begin
            r_cpuDone    <= 1'b0;
            r_misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_busErr     <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (io_lsu.cpu_req) begin
                        if (!w_aligned) begin
                            r_misaligned <= 1'b1;
                            r_cpuDone    <= 1'b1;
                            r_cpuRdata   <= 32'd0;
                            r_state      <= S_DONE;
                        end else begin
                            r_memReq   <= 1'b1;
                            r_memWe    <= io_lsu.cpu_we;
                            r_memAddr  <= {io_lsu.cpu_addr[ADDR_W-1:2], 2'b00};
                            r_memBe    <= w_be;
                            r_memWdata <= w_wdata;
                            r_lane     <= io_lsu.cpu_addr[1:0];
                            r_funct3   <= io_lsu.cpu_funct3;
`ifdef LSU_TIMEOUT_EN
                            r_waitCnt  <= '0;
`endif
                            r_state    <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    if (io_lsu.mem_ack) begin
                        r_memReq   <= 1'b0;
                        r_cpuRdata <= r_memWe ? 32'd0 : w_loadData;
                        r_cpuDone  <= 1'b1;
                        r_state    <= S_DONE;
`ifdef LSU_TIMEOUT_EN
                    end else if (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_memReq   <= 1'b0;
                        r_cpuRdata <= 32'd0;
                        r_cpuDone  <= 1'b1;
                        r_busErr   <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_waitCnt  <= r_waitCnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_lsu.cpu_rdata  = r_cpuRdata;
    assign io_lsu.cpu_done   = r_cpuDone;
    assign io_lsu.stall      = w_stall;
    assign io_lsu.misaligned = r_misaligned;
    assign io_lsu.mem_req    = r_memReq;
    assign io_lsu.mem_we     = r_memWe;
    assign io_lsu.mem_addr   = r_memAddr;
    assign io_lsu.mem_be     = r_memBe;
    assign io_lsu.mem_wdata  = r_memWdata;
`ifdef LSU_TIMEOUT_EN
    assign io_lsu.bus_err    = r_busErr;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench for load_store_unit. The driver issues directed and
// random accesses, computes each expected response from a byte-level model
// and queues it; a memory responder plays the data memory with a per-access
// ack delay; a monitor on the falling edge compares the DUT against the head
// of the queue every cycle.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int TMO = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int          planDelay = 0;
   logic [31:0] planRdata = 32'd0;
   int          busCnt    = 0;

   typedef struct {
      logic        mis;
      logic        err;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          issueCyc;
      int          doneCyc;
   } exp_t;

   exp_t expQ[$];

   load_store_unit_if #(.ADDR_W(32)) lsuBus();

   load_store_unit #(.ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .io_lsu(lsuBus)
   );

   // Free-running clock and a cycle counter used to time expectations.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Reference model: works on byte sizes, lanes and masks rather than the
   // funct3 case structure, and fixes the cycle on which the access must end.
   function automatic exp_t buildExpected(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [31:0] wdata,
                                          input logic [31:0] rdata, input int delay,
                                          input int issueCyc);
      exp_t        e;
      int          size;
      int          lane;
      logic [31:0] mask;
      logic [31:0] val;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      lane = int'(addr % 32'd4);
      e.mis   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((addr % size) != 0);
      e.err   = 1'b0;
      e.we    = we;
      e.addr  = addr - (addr % 32'd4);
      e.be    = 4'(((32'd1 << size) - 32'd1) << lane);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
      val  = (rdata >> (8*lane)) & mask;
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      e.rdata    = (e.mis || we) ? 32'd0 : val;
      e.issueCyc = issueCyc;
      if (e.mis) e.doneCyc = issueCyc + 1;
      else       e.doneCyc = issueCyc + 2 + delay;
`ifdef LSU_TIMEOUT_EN
      if (!e.mis && delay >= TMO) begin
         e.err     = 1'b1;
         e.rdata   = 32'd0;
         e.doneCyc = issueCyc + 1 + TMO;
      end
`endif
      return e;
   endfunction

   // Present one request, queue its expected response, and hold it until
   // the cycle the model says the access finishes.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
      exp_t e;
      @(posedge clk);
      #1;
      lsuBus.cpu_req    = 1'b1;
      lsuBus.cpu_we     = we;
      lsuBus.cpu_funct3 = f3;
      lsuBus.cpu_addr   = addr;
      lsuBus.cpu_wdata  = wdata;
      planDelay         = delay;
      planRdata         = rdata;
      e = buildExpected(we, f3, addr, wdata, rdata, delay, cyc);
      expQ.push_back(e);
      repeat (e.doneCyc - e.issueCyc) @(posedge clk);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         lsuBus.cpu_req = 1'b0;
      end
   endtask

   // Data memory model: acks after planDelay waiting cycles while mem_req is
   // up, and throws random acks at the LSU when no request is pending.
   always @(negedge clk) begin
      if (lsuBus.mem_req) begin
         lsuBus.mem_ack   = (busCnt == planDelay);
         lsuBus.mem_rdata = planRdata;
         busCnt++;
      end else begin
         busCnt           = 0;
         lsuBus.mem_ack   = ($urandom_range(0, 3) == 0);
         lsuBus.mem_rdata = $urandom;
      end
   end

   // Monitor: derives this cycle's expected outputs from the queue head and
   // retires the head on its completion cycle.
   always @(negedge clk) begin
      exp_t f;
      logic expDone, expStall, expReq, expMis, expErr;
      if (reset) begin
         expDone = 1'b0; expStall = 1'b0; expReq = 1'b0; expMis = 1'b0; expErr = 1'b0;
         f = '{default: '0};
         if (expQ.size() > 0) begin
            f        = expQ[0];
            expDone  = (cyc == f.doneCyc);
            expStall = (cyc < f.doneCyc);
            expReq   = !f.mis && (cyc > f.issueCyc) && (cyc < f.doneCyc);
            expMis   = expDone && f.mis;
            expErr   = expDone && f.err;
         end
         checkOutput("stall", 32'(lsuBus.stall), 32'(expStall));
         checkOutput("cpu_done", 32'(lsuBus.cpu_done), 32'(expDone));
         checkOutput("mem_req", 32'(lsuBus.mem_req), 32'(expReq));
         checkOutput("misaligned", 32'(lsuBus.misaligned), 32'(expMis));
`ifdef LSU_TIMEOUT_EN
         checkOutput("bus_err", 32'(lsuBus.bus_err), 32'(expErr));
`endif
         if (expReq) begin
            checkOutput("mem_addr", lsuBus.mem_addr, f.addr);
            checkOutput("mem_be", 32'(lsuBus.mem_be), 32'(f.be));
            checkOutput("mem_we", 32'(lsuBus.mem_we), 32'(f.we));
            if (f.we) checkOutput("mem_wdata", lsuBus.mem_wdata, f.wdata);
         end
         if (expDone) begin
            checkOutput("cpu_rdata", lsuBus.cpu_rdata, f.rdata);
            void'(expQ.pop_front());
         end
      end
   end

   // Hard stop in case something wedges the simulation itself.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed cases, random traffic, reset mid-bus.
   initial begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      exp_t        e;

      lsuBus.cpu_req    = 1'b0;
      lsuBus.cpu_we     = 1'b0;
      lsuBus.cpu_funct3 = 3'b000;
      lsuBus.cpu_addr   = 32'd0;
      lsuBus.cpu_wdata  = 32'd0;

      #3;
      checkOutput("reset mem_req", 32'(lsuBus.mem_req), 32'd0);
      checkOutput("reset cpu_done", 32'(lsuBus.cpu_done), 32'd0);
      checkOutput("reset stall", 32'(lsuBus.stall), 32'd0);
      checkOutput("reset cpu_rdata", lsuBus.cpu_rdata, 32'd0);
      checkOutput("reset mem_be", 32'(lsuBus.mem_be), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idleCycles(2);

      $display("[TB] directed accesses");
      applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0);
      applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 1);
      applyStimulus(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0);
      applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 2);
      applyStimulus(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'h1111_1111, 0);
      applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'hF00D_8001, 3);
      applyStimulus(1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'hF00D_8001, 0);
      applyStimulus(1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'h2222_2222, 0);
      applyStimulus(1'b1, 3'b000, 32'h0000_0041, 32'h0000_00A5, 32'd0, 0);
      idleCycles(2);

      $display("[TB] random accesses");
      for (int n = 0; n < 150; n++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ((f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && $urandom_range(0, 3) != 0) f3 = 3'd2;
         if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
         addr = 32'h0000_1000 + $urandom_range(0, 1023);
         applyStimulus(we, f3, addr, $urandom, $urandom, $urandom_range(0, 4));
         idleCycles($urandom_range(0, 2));
      end

`ifdef LSU_TIMEOUT_EN
      $display("[TB] store with no ack");
      applyStimulus(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'd0, 40);
      idleCycles(3);
`endif

      $display("[TB] reset during bus wait");
      @(posedge clk);
      #1;
      lsuBus.cpu_req    = 1'b1;
      lsuBus.cpu_we     = 1'b0;
      lsuBus.cpu_funct3 = 3'b001;
      lsuBus.cpu_addr   = 32'h0000_0010;
      lsuBus.cpu_wdata  = 32'd0;
      planDelay         = 5;
      planRdata         = 32'h1234_5678;
      e = buildExpected(1'b0, 3'b001, 32'h0000_0010, 32'd0, 32'h1234_5678, 5, cyc);
      expQ.push_back(e);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("mem_req before reset", 32'(lsuBus.mem_req), 32'd1);
      reset          = 1'b0;
      lsuBus.cpu_req = 1'b0;
      expQ.delete();
      #1;
      checkOutput("abort mem_req", 32'(lsuBus.mem_req), 32'd0);
      checkOutput("abort mem_addr", lsuBus.mem_addr, 32'd0);
      checkOutput("abort mem_be", 32'(lsuBus.mem_be), 32'd0);
      checkOutput("abort mem_we", 32'(lsuBus.mem_we), 32'd0);
      checkOutput("abort mem_wdata", lsuBus.mem_wdata, 32'd0);
      checkOutput("abort cpu_done", 32'(lsuBus.cpu_done), 32'd0);
      checkOutput("abort stall", 32'(lsuBus.stall), 32'd0);
      checkOutput("abort cpu_rdata", lsuBus.cpu_rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      idleCycles(6);
      applyStimulus(1'b0, 3'b010, 32'h0000_0020, 32'd0, 32'hA5A5_0F0F, 1);
      idleCycles(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
